// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes,
// func codes and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_IF      = 4'd1,
    S_ID      = 4'd2,
    S_EX_R    = 4'd3,
    S_WB_R    = 4'd4,
    S_EX_ADDR = 4'd5,
    S_MEM_LW  = 4'd6,
    S_WB_LW   = 4'd7,
    S_MEM_SW  = 4'd8,
    S_EX_BEQ  = 4'd9,
    S_EX_IMM  = 4'd10,
    S_WB_IMM  = 4'd11,
    S_JMP     = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_DIAG = 2'd2;
  localparam logic [1:0] ALUOP_NOP  = 2'd3;

  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_PC     = 2'd2;

endpackage

// File: rtl/mips_mc_controller.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences IF/ID/EX/MEM/WB
// and decodes every mux select and write enable from the current state.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       slt_sel
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       pc_write, pc_write_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_R;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode is captured in ID so later dispatch is immune to IR changes.
  assign op_d = (state_q == S_ID) ? opcode : op_q;

  always_comb begin
    state_d = S_IF;
    unique case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        unique case (opcode)
          OP_R:             state_d = (func == FUNC_JR) ? S_JR : S_EX_R;
          OP_LW, OP_SW:     state_d = S_EX_ADDR;
          OP_BEQ:           state_d = S_EX_BEQ;
          OP_ADDI, OP_SLTI: state_d = S_EX_IMM;
          OP_J:             state_d = S_JMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_IF;
        endcase
      end
      S_EX_R:    state_d = S_WB_R;
      S_EX_ADDR: state_d = (op_q == OP_SW) ? S_MEM_SW : S_MEM_LW;
      S_MEM_LW:  state_d = S_WB_LW;
      S_EX_IMM:  state_d = S_WB_IMM;
      default:   state_d = S_IF;
    endcase
  end

  always_comb begin
    aluop         = ALUOP_NOP;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_src        = PCSRC_ALU;
    reg_dst       = REGDST_RT;
    mem_to_reg    = MTR_ALUOUT;
    slt_sel       = 1'b0;
    unique case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        aluop     = ALUOP_ADD;
        pc_write  = 1'b1;
      end
      S_ID: begin
        alu_src_b = SRCB_IMM_SH;
        aluop     = ALUOP_ADD;
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_DIAG;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RD;
        slt_sel   = (func == FUNC_SLT);
      end
      S_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ADD;
      end
      S_MEM_LW: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = MTR_MDR;
      end
      S_MEM_SW: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EX_BEQ: begin
        alu_src_a     = 1'b1;
        aluop         = ALUOP_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_EX_IMM: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluop     = (op_q == OP_SLTI) ? ALUOP_SUB : ALUOP_ADD;
      end
      S_WB_IMM: begin
        reg_write = 1'b1;
        slt_sel   = (op_q == OP_SLTI);
      end
      S_JMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = REGDST_R31;
        mem_to_reg = MTR_PC;
      end
      S_JR: begin
        pc_src   = PCSRC_REGA;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle expected output vectors are
// queued as stimulus is driven and compared when the cycle's outputs settle.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero;
  logic [1:0] aluop, alu_src_b, pc_src, reg_dst, mem_to_reg;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, slt_sel;

  mips_mc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .aluop(aluop), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .slt_sel(slt_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } sb_t;

  sb_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
    BEQ = 6'b000100, ADDI = 6'b001000, SLTI = 6'b001010, J = 6'b000010,
    JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLT = 6'b101010, F_JR = 6'b001000;

  // {aluop, pc_en, iord, mem_read, mem_write, ir_write, reg_write, src_a,
  //  src_b, pc_src, reg_dst, mem_to_reg, slt_sel}
  function automatic logic [17:0] mk(input logic [1:0] aop, input logic pce, io,
      mr, mw, irw, rw, sa, input logic [1:0] sb, ps, rd, mtr, input logic slt);
    return {aop, pce, io, mr, mw, irw, rw, sa, sb, ps, rd, mtr, slt};
  endfunction

  function automatic logic [17:0] e_idle();        return mk(3,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [17:0] e_if();          return mk(0,1,0,1,0,1,0,0,1,0,0,0,0); endfunction
  function automatic logic [17:0] e_id();          return mk(0,0,0,0,0,0,0,0,3,0,0,0,0); endfunction
  function automatic logic [17:0] e_exr();         return mk(2,0,0,0,0,0,0,1,0,0,0,0,0); endfunction
  function automatic logic [17:0] e_wbr(input logic s);  return mk(3,0,0,0,0,0,1,0,0,0,1,0,s); endfunction
  function automatic logic [17:0] e_exaddr();      return mk(0,0,0,0,0,0,0,1,2,0,0,0,0); endfunction
  function automatic logic [17:0] e_memlw();       return mk(3,0,1,1,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [17:0] e_wblw();        return mk(3,0,0,0,0,0,1,0,0,0,0,1,0); endfunction
  function automatic logic [17:0] e_memsw();       return mk(3,0,1,0,1,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [17:0] e_beq(input logic z);  return mk(1,z,0,0,0,0,0,1,0,1,0,0,0); endfunction
  function automatic logic [17:0] e_eximm(input logic s); return mk({1'b0,s},0,0,0,0,0,0,1,2,0,0,0,0); endfunction
  function automatic logic [17:0] e_wbimm(input logic s); return mk(3,0,0,0,0,0,1,0,0,0,0,0,s); endfunction
  function automatic logic [17:0] e_jmp();         return mk(3,1,0,0,0,0,0,0,0,2,0,0,0); endfunction
  function automatic logic [17:0] e_jal();         return mk(3,1,0,0,0,0,1,0,0,2,2,2,0); endfunction
  function automatic logic [17:0] e_jr();          return mk(3,1,0,0,0,0,0,0,0,3,0,0,0); endfunction

  // Called just after a rising edge: drive, queue expectation, check at the
  // falling edge, then advance to just after the next rising edge.
  task automatic step(input logic r, input logic [5:0] opc, fn, input logic z,
                      input logic [17:0] e, input string tag);
    sb_t         s;
    logic [17:0] obs;
    rst = r; opcode = opc; func = fn; zero = z;
    q.push_back('{tag: tag, exp: e});
    @(negedge clk);
    s   = q.pop_front();
    obs = {aluop, pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a,
           alu_src_b, pc_src, reg_dst, mem_to_reg, slt_sel};
    n_chk++;
    assert (obs === s.exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", s.tag, obs, s.exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; opcode = R; func = F_ADD; zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(0, R, F_ADD, 1, e_idle(), "reset_idle");

    step(0, R, F_ADD, 1, e_if(),     "add_if");
    step(0, R, F_ADD, 1, e_id(),     "add_id");
    step(0, R, F_ADD, 1, e_exr(),    "add_exr");
    step(0, R, F_ADD, 1, e_wbr(0),   "add_wbr");

    step(0, R, F_SLT, 1, e_if(),     "slt_if");
    step(0, R, F_SLT, 1, e_id(),     "slt_id");
    step(0, R, F_SLT, 1, e_exr(),    "slt_exr");
    step(0, R, F_SLT, 1, e_wbr(1),   "slt_wbr");

    // Live opcode changes after ID must not redirect the latched lw.
    step(0, LW, 0, 1, e_if(),        "lw_if");
    step(0, LW, 0, 1, e_id(),        "lw_id");
    step(0, SW, 0, 1, e_exaddr(),    "lw_exaddr");
    step(0, SW, 0, 1, e_memlw(),     "lw_mem");
    step(0, SW, 0, 1, e_wblw(),      "lw_wb");

    step(0, SW, 0, 1, e_if(),        "sw_if");
    step(0, SW, 0, 1, e_id(),        "sw_id");
    step(0, SW, 0, 1, e_exaddr(),    "sw_exaddr");
    step(0, SW, 0, 1, e_memsw(),     "sw_mem");

    step(0, BEQ, 0, 1, e_if(),       "beqt_if");
    step(0, BEQ, 0, 1, e_id(),       "beqt_id");
    step(0, BEQ, 0, 1, e_beq(1),     "beqt_ex");
    step(0, BEQ, 0, 0, e_if(),       "beqn_if");
    step(0, BEQ, 0, 0, e_id(),       "beqn_id");
    step(0, BEQ, 0, 0, e_beq(0),     "beqn_ex");

    step(0, ADDI, 0, 1, e_if(),      "addi_if");
    step(0, ADDI, 0, 1, e_id(),      "addi_id");
    step(0, ADDI, 0, 1, e_eximm(0),  "addi_ex");
    step(0, ADDI, 0, 1, e_wbimm(0),  "addi_wb");

    step(0, SLTI, 0, 1, e_if(),      "slti_if");
    step(0, SLTI, 0, 1, e_id(),      "slti_id");
    step(0, ADDI, 0, 1, e_eximm(1),  "slti_ex");
    step(0, ADDI, 0, 1, e_wbimm(1),  "slti_wb");

    step(0, J, 0, 1, e_if(),         "j_if");
    step(0, J, 0, 1, e_id(),         "j_id");
    step(0, J, 0, 1, e_jmp(),        "j_ex");

    step(0, JAL, 0, 1, e_if(),       "jal_if");
    step(0, JAL, 0, 1, e_id(),       "jal_id");
    step(0, JAL, 0, 1, e_jal(),      "jal_ex");

    step(0, R, F_JR, 1, e_if(),      "jr_if");
    step(0, R, F_JR, 1, e_id(),      "jr_id");
    step(0, R, F_JR, 1, e_jr(),      "jr_ex");

    step(0, BAD, 0, 1, e_if(),       "bad_if");
    step(0, BAD, 0, 1, e_id(),       "bad_id");

    step(0, LW, 0, 1, e_if(),        "lwr_if");
    step(0, LW, 0, 1, e_id(),        "lwr_id");
    step(0, LW, 0, 1, e_exaddr(),    "lwr_exaddr");
    step(1, LW, 0, 1, e_memlw(),     "lwr_mem_rst");
    step(0, LW, 0, 1, e_idle(),      "lwr_idle");
    step(0, LW, 0, 1, e_if(),        "lwr_if2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Moore-style main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the two-bit `aluop` code consumed by the ALU control decoder, plus every mux select and write enable in the datapath. Sits between the instruction register (opcode/func fields) and the shared datapath, and replaces the single-cycle combinational main decoder.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; sampled in ID only.
- `func`  in  6  IR[5:0]; sampled in ID and WB_R.
- `zero`  in  1  ALU zero flag; used in EX_BEQ.
- `aluop`  out  2  0 = push_add, 1 = push_sub, 2 = diagnostic (decode func), 3 = nop.
- `pc_en`  out  1  PC write enable = pc_write | (pc_write_cond & zero).
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each.
- `alu_src_a`  out  1  0 = PC, 1 = reg A.
- `alu_src_b`  out  2  0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target {PC[31:28], IR[25:0], 2'b00}, 3 = reg A.
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = r31.
- `mem_to_reg`  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- `slt_sel`  out  1  write-back value = {31'b0, ALUOut[31]}.

## Operation
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, slti = 001010, j = 000010, jal = 000011. jr is R-type with func 001000.
- Outputs are a pure function of state. Any signal not listed for a state is 0; `aluop` defaults to nop.
- States and outputs:
  - IDLE: all inactive, aluop = nop. Always goes to IF.
  - IF: mem_read, ir_write, iord=0, src_a=0, src_b=1, aluop=add, pc_src=0, pc_write. Goes to ID.
  - ID: src_a=0, src_b=3, aluop=add (branch target into ALUOut). Dispatches on opcode:
    - R with func≠jr → EX_R; R with func=jr → JR.
    - lw, sw → EX_ADDR; beq → EX_BEQ; addi, slti → EX_IMM; j → JMP; jal → JAL.
    - Any other opcode → IF, with no register or memory write.
  - EX_R: src_a=1, src_b=0, aluop=diagnostic. Goes to WB_R.
  - WB_R: reg_write, reg_dst=1, mem_to_reg=0; slt_sel=1 iff func=101010. Goes to IF.
  - EX_ADDR: src_a=1, src_b=2, aluop=add. lw goes to MEM_LW; sw goes to MEM_SW.
  - MEM_LW: mem_read, iord=1. Goes to WB_LW.
  - WB_LW: reg_write, reg_dst=0, mem_to_reg=1. Goes to IF.
  - MEM_SW: mem_write, iord=1. Goes to IF.
  - EX_BEQ: src_a=1, src_b=0, aluop=sub, pc_src=1, pc_write_cond. Goes to IF.
  - EX_IMM: src_a=1, src_b=2, aluop=add for addi and sub for slti. Goes to WB_IMM.
  - WB_IMM: reg_write, reg_dst=0, mem_to_reg=0; slt_sel=1 for slti. Goes to IF.
  - JMP: pc_src=2, pc_write. Goes to IF.
  - JAL: pc_src=2, pc_write, reg_write, reg_dst=2, mem_to_reg=2 (PC already +4). Goes to IF.
  - JR: pc_src=3, pc_write. Goes to IF.
- Opcode is latched into an internal register in ID. Later dispatch (EX_ADDR, EX_IMM, WB_IMM) uses the latched copy, not the live input.

## Timing
- Reset: `rst` high at a rising edge forces state to IDLE. While in IDLE every output is 0 and aluop = 3. The first IF occurs on the cycle after `rst` drops.
- Reset mid-instruction aborts the instruction. No write enable may be asserted in the cycle after the reset edge.
- Cycles per instruction, counting IF through the last state:
  - j, jal, jr, beq: 3
  - R-type, sw, addi, slti: 4
  - lw: 5
  - illegal opcode: 2
- beq: `zero` is sampled combinationally in EX_BEQ. `pc_en` follows `zero` in the same cycle.
- ID's branch-target computation is harmless for non-branches, since ALUOut is overwritten later.

## Structure
- Package `mips_mc_pkg` holds:
  - state encoding (4-bit enum, IDLE = 0)
  - opcode and func constants
  - aluop constants (push_add, push_sub, diagnostic, nop)
  - alu_src_b, pc_src, reg_dst and mem_to_reg select encodings
- Single module: a next-state process plus an output-decode process. No sub-module.

## Test plan
- Reset: hold `rst` 2 cycles, release. Outputs all 0 and aluop=3 for one cycle, then IF with mem_read=ir_write=pc_en=1 and aluop=0.
- add (opcode 0, func 100000): IF, ID, EX_R (aluop=2, src_b=0), WB_R (reg_write=1, reg_dst=1, slt_sel=0). Back in IF on cycle 5.
- lw: iord=1 with mem_read in cycle 4. reg_write with mem_to_reg=1 in cycle 5. sw: mem_write=1 in cycle 4 only.
- beq: with zero=1 in cycle 3, pc_en=1 and pc_src=1. With zero=0, pc_en=0. Both return to IF at cycle 4.
- jal: cycle 3 has pc_en=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. jr (func 001000): cycle 3 has pc_src=3, and aluop never equals 2.
- Opcode 111111: returns to IF after ID with reg_write and mem_write never asserted. Asserting `rst` during MEM_LW yields IDLE next cycle with no reg_write.
